// File: rtl/timer_pkg.sv
// Shared types and default timing constants for the clock/timer alarm path.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2,
    HOLD   = 2'd3
  } ring_state_t;

  localparam int RING_SEC_DEF   = 60;
  localparam int SNOOZE_SEC_DEF = 300;
  localparam int MAX_SNOOZE_DEF = 3;

endpackage

// File: rtl/alarm_ring_ctrl_sec_counter.sv
// Tick-enabled seconds counter with sync clear and a terminal-count flag.
// The terminal value is an input so RING and SNOOZE can share one counter.
module sec_counter #(
  parameter int N = 300,
  parameter int W = $clog2(N + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         tc
);

  // Saturates at N so a missed transition can never alias by wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      cnt <= '0;
    else if (clear)                 cnt <= '0;
    else if (en && cnt != W'(N))    cnt <= cnt + W'(1);
  end

  assign tc = (cnt == term);

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Alarm ring/snooze/dismiss sequencer driving the alarm LED.
module alarm_ring_ctrl
  import timer_pkg::*;
#(
  parameter int RING_SEC   = RING_SEC_DEF,
  parameter int SNOOZE_SEC = SNOOZE_SEC_DEF,
  parameter int MAX_SNOOZE = MAX_SNOOZE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       alarm_en,
  input  logic       match,
  input  logic       btn_short,
  input  logic       btn_long,
  input  logic       blink,
  output logic       led_alarm,
  output logic       ringing,
  output logic       snoozed,
  output logic [1:0] snooze_cnt,
  output logic       ring_done
);

  localparam int CNT_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] RING_TERM   = CW'(RING_SEC - 1);
  localparam logic [CW-1:0] SNOOZE_TERM = CW'(SNOOZE_SEC - 1);
  localparam logic [1:0]    SNZ_LIMIT   = 2'(MAX_SNOOZE);

  ring_state_t   state, next_state;
  logic          match_d, primed, trig;
  logic [1:0]    snooze_nxt;
  logic          done_nxt;
  logic          cnt_clear, cnt_tc;
  logic [CW-1:0] cnt_term, sec_cnt;

  // primed stays low for the first post-reset cycle so match_d is seeded from
  // match before any edge can be seen; a match held through reset never rings.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match_d <= 1'b0;
      primed  <= 1'b0;
      trig    <= 1'b0;
    end else begin
      match_d <= match;
      primed  <= 1'b1;
      trig    <= primed & match & ~match_d & alarm_en;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    snooze_nxt = snooze_cnt;
    done_nxt   = 1'b0;
    unique case (state)
      IDLE: if (trig) begin
        next_state = RING;
        snooze_nxt = 2'd0;
      end
      RING: begin
        if (!alarm_en) begin
          next_state = HOLD;
          done_nxt   = 1'b1;
        end else if (btn_short || (btn_long && snooze_cnt >= SNZ_LIMIT)) begin
          next_state = HOLD;
          done_nxt   = 1'b1;
          snooze_nxt = 2'd0;
        end else if (btn_long) begin
          next_state = SNOOZE;
          snooze_nxt = snooze_cnt + 2'd1;
        end else if (tick_1hz && cnt_tc) begin
          next_state = HOLD;
          done_nxt   = 1'b1;
        end
      end
      SNOOZE: begin
        if (!alarm_en || btn_short) begin
          next_state = HOLD;
          done_nxt   = 1'b1;
        end else if (tick_1hz && cnt_tc) begin
          next_state = RING;
        end
      end
      HOLD: if (!match) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Any state change restarts the count, which also drops a tick that
  // coincides with a button press.
  assign cnt_clear = (next_state != state);
  assign cnt_term  = (state == SNOOZE) ? SNOOZE_TERM : RING_TERM;

  sec_counter #(.N(CNT_MAX), .W(CW)) u_sec (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .en    (tick_1hz),
    .term  (cnt_term),
    .cnt   (sec_cnt),
    .tc    (cnt_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snooze_cnt <= 2'd0;
      ringing    <= 1'b0;
      snoozed    <= 1'b0;
      led_alarm  <= 1'b0;
      ring_done  <= 1'b0;
    end else begin
      snooze_cnt <= snooze_nxt;
      ringing    <= (next_state == RING);
      snoozed    <= (next_state == SNOOZE);
      led_alarm  <= blink & (next_state == RING);
      ring_done  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Directed bench for alarm_ring_ctrl with an event-level reference model.
module tb_alarm_ring_ctrl;

  localparam int RS = 60;
  localparam int SS = 300;
  localparam int MS = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1hz = 1'b0, alarm_en = 1'b0, match = 1'b0;
  logic       btn_short = 1'b0, btn_long = 1'b0, blink = 1'b0;
  logic       led_alarm, ringing, snoozed, ring_done;
  logic [1:0] snooze_cnt;

  int tests = 0;
  int fails = 0;

  alarm_ring_ctrl #(.RING_SEC(RS), .SNOOZE_SEC(SS), .MAX_SNOOZE(MS)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick_1hz   (tick_1hz),
    .alarm_en   (alarm_en),
    .match      (match),
    .btn_short  (btn_short),
    .btn_long   (btn_long),
    .blink      (blink),
    .led_alarm  (led_alarm),
    .ringing    (ringing),
    .snoozed    (snoozed),
    .snooze_cnt (snooze_cnt),
    .ring_done  (ring_done)
  );

  always #5 clk = ~clk;

  initial forever begin
    repeat (3) @(posedge clk);
    #2 blink = ~blink;
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the alarm is an "event" that is either sounding, snoozing or
  // waiting for the matching second to end; seconds are counted upward.
  bit m_ring, m_snz, m_hold, m_prev, m_primed, m_pend, m_done, m_led;
  int m_secs, m_uses;

  always @(posedge clk or posedge reset) begin
    bit fire, dismiss;
    if (reset) begin
      m_ring = 0; m_snz = 0; m_hold = 0; m_prev = 0; m_primed = 0;
      m_pend = 0; m_done = 0; m_led = 0; m_secs = 0; m_uses = 0;
    end else begin
      fire     = m_pend;
      m_done   = 0;
      m_pend   = m_primed && match && !m_prev && alarm_en;
      m_prev   = match;
      m_primed = 1;
      if (m_ring || m_snz) begin
        dismiss = btn_short || (m_ring && btn_long && m_uses == MS);
        if (!alarm_en || dismiss) begin
          if (alarm_en && m_ring) m_uses = 0;
          m_ring = 0; m_snz = 0; m_hold = 1; m_done = 1;
        end else if (m_ring && btn_long) begin
          m_ring = 0; m_snz = 1; m_uses++; m_secs = 0;
        end else if (tick_1hz) begin
          m_secs++;
          if (m_ring && m_secs == RS) begin
            m_ring = 0; m_hold = 1; m_done = 1;
          end else if (m_snz && m_secs == SS) begin
            m_snz = 0; m_ring = 1; m_secs = 0;
          end
        end
      end else if (m_hold) begin
        if (!match) m_hold = 0;
      end else if (fire) begin
        m_ring = 1; m_secs = 0; m_uses = 0;
      end
      m_led = blink && m_ring;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("ringing",    ringing,    m_ring);
      chk("snoozed",    snoozed,    m_snz);
      chk("snooze_cnt", snooze_cnt, m_uses);
      chk("ring_done",  ring_done,  m_done);
      chk("led_alarm",  led_alarm,  m_led);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick_1hz = 1'b1; step();
      tick_1hz = 1'b0; step(2);
    end
  endtask

  task automatic press_long();
    btn_long = 1'b1; step();
    btn_long = 1'b0;
  endtask

  initial begin
    step(3);
    chk("rst_ringing", ringing, 0);
    chk("rst_led", led_alarm, 0);
    chk("rst_done", ring_done, 0);
    reset = 1'b0;
    step(2);

    // trigger, then ring timeout while match still high
    alarm_en = 1'b1;
    match = 1'b1;
    step();
    chk("trig_lat1", ringing, 0);
    step();
    chk("trig_lat2", ringing, 1);
    ticks(RS - 1);
    chk("ring_59", ringing, 1);
    tick_1hz = 1'b1; step(); tick_1hz = 1'b0;
    chk("timeout_done", ring_done, 1);
    chk("timeout_ring", ringing, 0);
    step();
    chk("done_pulse", ring_done, 0);
    step(5);
    chk("hold_no_ring", ringing, 0);
    match = 1'b0;
    step(2);

    // snooze and re-ring up to the limit
    match = 1'b1; step(2);
    press_long();
    chk("snz1", snoozed, 1);
    chk("snz1_cnt", snooze_cnt, 1);
    match = 1'b0;
    ticks(SS);
    chk("rering", ringing, 1);
    chk("rering_cnt", snooze_cnt, 1);
    press_long(); ticks(SS);
    press_long(); ticks(SS);
    chk("cnt3", snooze_cnt, 3);
    press_long();
    chk("limit_done", ring_done, 1);
    chk("limit_snz", snoozed, 0);
    chk("limit_ring", ringing, 0);
    step(2);

    // short+long together dismisses
    match = 1'b1; step(2);
    btn_short = 1'b1; btn_long = 1'b1; step();
    btn_short = 1'b0; btn_long = 1'b0;
    chk("both_done", ring_done, 1);
    chk("both_snz", snoozed, 0);
    match = 1'b0; step(2);

    // tick coinciding with snooze is not counted
    match = 1'b1; step(2);
    match = 1'b0;
    ticks(5);
    tick_1hz = 1'b1; btn_long = 1'b1; step();
    tick_1hz = 1'b0; btn_long = 1'b0;
    chk("coll_snz", snoozed, 1);
    ticks(SS - 1);
    chk("coll_299", snoozed, 1);
    ticks(1);
    chk("coll_rering", ringing, 1);

    // disable during snooze; same matching second stays blocked in HOLD
    step(2);
    btn_short = 1'b1; step(); btn_short = 1'b0;
    step(2);
    match = 1'b1; step(2);
    press_long();
    alarm_en = 1'b0; step();
    chk("dis_done", ring_done, 1);
    chk("dis_snz", snoozed, 0);
    alarm_en = 1'b1;
    step(10);
    chk("dis_hold", ringing, 0);
    match = 1'b0; step(2);
    match = 1'b1; step(2);
    chk("dis_rearm", ringing, 1);

    // reset mid-ring with match held high
    #1 reset = 1'b1;
    #1;
    chk("arst_ring", ringing, 0);
    chk("arst_led", led_alarm, 0);
    chk("arst_cnt", snooze_cnt, 0);
    step(2);
    reset = 1'b0;
    step(5);
    chk("post_rst_ring", ringing, 0);
    match = 1'b0; step();
    match = 1'b1; step(2);
    chk("post_rst_rering", ringing, 1);
    step(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
